// File: rtl/fsk_pkg.sv
// Shared constants and types for the FSK frame scheduler.
// Optional parity bit is controlled by the macro FSK_FRAME_PARITY_EN.
package fsk_pkg;

    // Frame header, transmitted MSB first: 1,1,0
    localparam logic [2:0] HDR     = 3'b110;
    localparam int         HDR_LEN = 3;

`ifdef FSK_FRAME_PARITY_EN
    localparam int PAR_LEN = 1;
`else
    localparam int PAR_LEN = 0;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Total frame length in bit-cycles for a given payload width
    function automatic int frame_len(input int data_w);
        return HDR_LEN + data_w + PAR_LEN;
    endfunction

endpackage

// File: rtl/fsk_rr_arb.sv
// Round-robin arbiter: search starts just above last_grant and wraps.
module fsk_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    // First requester found walking upward from last_grant+1 wins
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((int'(last_grant) + off) % NUM_REQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/fsk_frame_sched.sv
// FSK frame scheduler: arbitrates requesters round-robin and serialises
// header, payload (LSB first) and optional parity, back-to-back.
// Parity bit appended when FSK_FRAME_PARITY_EN is defined.
module fsk_frame_sched
    import fsk_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       ser_out,
    output logic                       ser_valid,
    output logic                       frame_start,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int FL    = frame_len(DATA_W);
    localparam int CNT_W = $clog2(FL);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   payload_q, payload_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                ser_out_q, ser_out_d;
    logic                ser_valid_q, ser_valid_d;
    logic                frame_start_q, frame_start_d;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic [DATA_W-1:0]   sel_payload;
    logic [FL-1:0]       frame_vec;
    logic                grant_ok;

    // Frame laid out so that bit k of the vector is sent in bit-cycle k
    function automatic logic [FL-1:0] build_frame(input logic [DATA_W-1:0] p);
`ifdef FSK_FRAME_PARITY_EN
        return {^p, p, HDR[0], HDR[1], HDR[2]};
`else
        return {p, HDR[0], HDR[1], HDR[2]};
`endif
    endfunction

    fsk_rr_arb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req        (req),
        .last_grant (last_q),
        .grant      (arb_grant),
        .idx        (arb_idx),
        .any        (arb_any)
    );

    // Payload of the arbitration winner
    always_comb begin
        sel_payload = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (arb_grant[i]) sel_payload = req_data[i*DATA_W +: DATA_W];
    end

    // Next state: arbitrate in IDLE or on the last bit, otherwise shift out
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        payload_d     = payload_q;
        last_d        = last_q;
        owner_d       = owner_q;
        ack_d         = '0;
        ser_out_d     = 1'b0;
        ser_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_vec     = build_frame(payload_q);
        grant_ok      = (state_q == IDLE) || (cnt_q == CNT_W'(FL - 1));
        if (grant_ok) begin
            cnt_d = '0;
            if (arb_any) begin
                state_d       = SEND;
                payload_d     = sel_payload;
                last_d        = arb_idx;
                owner_d       = arb_idx;
                ack_d         = arb_grant;
                frame_start_d = 1'b1;
                ser_valid_d   = 1'b1;
                ser_out_d     = HDR[HDR_LEN-1];
            end else begin
                state_d = IDLE;
            end
        end else begin
            cnt_d       = cnt_q + CNT_W'(1);
            ser_valid_d = 1'b1;
            ser_out_d   = frame_vec[cnt_d];
        end
    end

    // State and registered outputs; reset abandons any frame in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            payload_q     <= '0;
            last_q        <= IDX_W'(NUM_REQ - 1);
            owner_q       <= '0;
            ack_q         <= '0;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            payload_q     <= payload_d;
            last_q        <= last_d;
            owner_q       <= owner_d;
            ack_q         <= ack_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign ack         = ack_q;
    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign owner       = owner_q;
    assign busy        = (state_q == SEND);

endmodule

// File: doc/fsk_frame_sched.md
FSK_FRAME_SCHED -- requirements
Module: fsk_frame_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the FSK serial frame path.
REQ-002 SHALL have parameter DATA_W, default 4, payload bits per frame.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester frame request level.
REQ-006 SHALL have port req_data  input  NUM_REQ*DATA_W  payloads, requester i at bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port ack  output  NUM_REQ  one-hot, one-cycle pulse; payload of that requester accepted.
REQ-008 SHALL have port ser_out  output  1  serial frame bit.
REQ-009 SHALL have port ser_valid  output  1  high in every cycle ser_out carries a frame bit.
REQ-010 SHALL have port frame_start  output  1  high in first header-bit cycle only.
REQ-011 SHALL have port owner  output  $clog2(NUM_REQ)  index of requester whose frame is on ser_out.
REQ-012 SHALL have port busy  output  1  high while FSM is in SEND.

Function
REQ-013 SHALL implement FSM states IDLE and SEND; reset state IDLE.
REQ-014 Frame SHALL be, in order: header 1,1,0; payload bit 0 first through bit DATA_W-1; parity bit (with FRAME_PARITY_EN); FRAME_LEN = 3+DATA_W(+1) = 8 at defaults.
REQ-015 Parity SHALL be XOR of the latched payload bits (even parity, 1-bit sum truncation).
REQ-016 In IDLE with any req bit high at edge N, SHALL grant the round-robin winner: latch its payload, set owner, enter SEND; in cycle N+1 ack[winner]=1, frame_start=1, ser_valid=1, ser_out=1.
REQ-017 Frame bits SHALL occupy exactly FRAME_LEN consecutive cycles, one bit per cycle, registered outputs.
REQ-018 Round-robin SHALL search from (last_grant+1) mod NUM_REQ upward with wrap; last_grant resets to NUM_REQ-1 so requester 0 wins first.
REQ-019 At the edge ending the last frame bit, if any req high, SHALL arbitrate and start next frame in the immediately following cycle (no gap); else SHALL return to IDLE with ser_valid=0, busy=0.
REQ-020 req SHALL be ignored during SEND except at the last-bit edge; payload changes after ack SHALL not affect the current frame.
REQ-021 A requester still asserting req in the cycle after its ack SHALL be treated as a new request.
REQ-022 A req deasserted before ack SHALL be treated as withdrawn; no frame, no ack.
REQ-023 ack SHALL never be asserted for more than one requester or for more than one cycle per frame.
REQ-024 In IDLE, ser_out SHALL be 0 and ser_valid, frame_start SHALL be 0.

Reset
REQ-025 reset low SHALL immediately force: state IDLE, ser_out=0, ser_valid=0, frame_start=0, ack=0, busy=0, owner=0, bit counter 0, last_grant=NUM_REQ-1.
REQ-026 Reset mid-frame SHALL abandon the frame without re-ack; first frame after release follows REQ-016.

Configuration
REQ-027 Macro FSK_FRAME_PARITY_EN defined SHALL append the parity bit (FRAME_LEN=DATA_W+4); undefined SHALL omit it (FRAME_LEN=DATA_W+3), all other behaviour unchanged.

Structure
REQ-028 Package fsk_pkg SHALL hold header constant 3'b110, header length 3, state enum (IDLE, SEND), and FRAME_LEN derivation.
REQ-029 Round-robin selection SHALL be a sub-module fsk_rr_arb (inputs req, last_grant; outputs one-hot grant, index, any).

Verification
REQ-030 req=4'b0001, data0=4'b1011, parity on -> ack[0] one cycle; ser_out 1,1,0,1,1,0,1,1 over 8 cycles with ser_valid high; owner=0.
REQ-031 req=4'b1111 held, data_i=i -> frames back-to-back in owner order 0,1,2,3,0; no idle cycle between frames; one ack per frame.
REQ-032 req[2] pulsed high one cycle while busy (not at last-bit edge) -> no ack[2], no frame for requester 2.
REQ-033 reset low at frame bit 4 -> all outputs 0 same cycle; after release with req=4'b0100, owner=2 frame starts per REQ-016.
REQ-034 Parity off build, data=4'b0110 -> 7-bit frame 1,1,0,0,1,1,0; next frame starts on cycle 8.
REQ-035 Payload changed to 4'b0000 the cycle after ack -> transmitted payload and parity reflect value latched at grant.
